// File: rtl/dual_grant_arbiter.sv
// Two-unit fixed-priority arbiter for 12 requesters: grants the top two eligible
// requests to units A and B, holding each grant until done or a hold timeout.
module dual_grant_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] req,
    input  logic        done_a,
    input  logic        done_b,
    output logic        gnt_a_valid,
    output logic [3:0]  gnt_a_id,
    output logic        gnt_b_valid,
    output logic [3:0]  gnt_b_id,
    output logic [11:0] gnt_onehot,
    output logic        timeout_a,
    output logic        timeout_b
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

    state_t      a_state_q, a_state_d, b_state_q, b_state_d;
    logic [3:0]  a_id_q, a_id_d, b_id_q, b_id_d;
    logic [7:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
    logic        a_to_q, a_to_d, b_to_q, b_to_d;
    logic [11:0] onehot_q, onehot_d;

    logic [11:0] held, eligible;
    logic [3:0]  first, second, cand_b;

    function automatic logic [11:0] dec(input logic [3:0] id);
        logic [11:0] r;
        r = '0;
        if (id != 4'd0) r[id - 4'd1] = 1'b1;
        return r;
    endfunction

    // Ascending scan so the highest set bit is the one left in r.
    function automatic logic [3:0] top(input logic [11:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 12; i++)
            if (v[i]) r = 4'(i + 1);
        return r;
    endfunction

    always_comb begin
        held     = (a_state_q == BUSY ? dec(a_id_q) : '0)
                 | (b_state_q == BUSY ? dec(b_id_q) : '0);
        eligible = req & ~held;
        first    = top(eligible);
        second   = top(eligible & ~dec(first));
        // B takes the runner-up only when A is also arbitrating this edge.
        cand_b   = (a_state_q == IDLE) ? second : first;

        a_state_d = a_state_q;
        a_id_d    = a_id_q;
        a_cnt_d   = a_cnt_q;
        a_to_d    = 1'b0;
        b_state_d = b_state_q;
        b_id_d    = b_id_q;
        b_cnt_d   = b_cnt_q;
        b_to_d    = 1'b0;

        if (a_state_q == BUSY) begin
            if (done_a) begin
                a_state_d = IDLE;
                a_id_d    = '0;
            end else if (a_cnt_q == CNT_LAST) begin
                a_state_d = IDLE;
                a_id_d    = '0;
                a_to_d    = 1'b1;
            end else begin
                a_cnt_d = a_cnt_q + 8'd1;
            end
        end else if (first != 4'd0) begin
            a_state_d = BUSY;
            a_id_d    = first;
            a_cnt_d   = '0;
        end

        if (b_state_q == BUSY) begin
            if (done_b) begin
                b_state_d = IDLE;
                b_id_d    = '0;
            end else if (b_cnt_q == CNT_LAST) begin
                b_state_d = IDLE;
                b_id_d    = '0;
                b_to_d    = 1'b1;
            end else begin
                b_cnt_d = b_cnt_q + 8'd1;
            end
        end else if (cand_b != 4'd0) begin
            b_state_d = BUSY;
            b_id_d    = cand_b;
            b_cnt_d   = '0;
        end

        onehot_d = dec(a_id_d) | dec(b_id_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_state_q <= IDLE;
            a_id_q    <= '0;
            a_cnt_q   <= '0;
            a_to_q    <= 1'b0;
            b_state_q <= IDLE;
            b_id_q    <= '0;
            b_cnt_q   <= '0;
            b_to_q    <= 1'b0;
            onehot_q  <= '0;
        end else begin
            a_state_q <= a_state_d;
            a_id_q    <= a_id_d;
            a_cnt_q   <= a_cnt_d;
            a_to_q    <= a_to_d;
            b_state_q <= b_state_d;
            b_id_q    <= b_id_d;
            b_cnt_q   <= b_cnt_d;
            b_to_q    <= b_to_d;
            onehot_q  <= onehot_d;
        end
    end

    assign gnt_a_valid = (a_state_q == BUSY);
    assign gnt_a_id    = a_id_q;
    assign gnt_b_valid = (b_state_q == BUSY);
    assign gnt_b_id    = b_id_q;
    assign gnt_onehot  = onehot_q;
    assign timeout_a   = a_to_q;
    assign timeout_b   = b_to_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Bench for dual_grant_arbiter: directed scenarios plus random traffic, all
// compared against a cycle-level reference model of the arbitration rules.
module tb_dual_grant_arbiter;

    localparam int HOLD = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] req = '0;
    logic        done_a = 1'b0;
    logic        done_b = 1'b0;
    logic        gnt_a_valid, gnt_b_valid, timeout_a, timeout_b;
    logic [3:0]  gnt_a_id, gnt_b_id;
    logic [11:0] gnt_onehot;

    int checks = 0;
    int errors = 0;

    // Reference model: per-unit busy flag, served id, and cycles served so far.
    int m_busy[2];
    int m_id[2];
    int m_age[2];
    int m_to[2];

    dual_grant_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .done_a(done_a), .done_b(done_b),
        .gnt_a_valid(gnt_a_valid), .gnt_a_id(gnt_a_id),
        .gnt_b_valid(gnt_b_valid), .gnt_b_id(gnt_b_id),
        .gnt_onehot(gnt_onehot), .timeout_a(timeout_a), .timeout_b(timeout_b)
    );

    always #5 clk = ~clk;

    wire [23:0] dut_vec = {gnt_a_valid, gnt_a_id, gnt_b_valid, gnt_b_id,
                           gnt_onehot, timeout_a, timeout_b};

    function automatic int bit_of(input int id);
        return (id == 0) ? 0 : (1 << (id - 1));
    endfunction

    function automatic int highest(input int v);
        for (int i = 11; i >= 0; i--)
            if (((v >> i) & 1) == 1) return i + 1;
        return 0;
    endfunction

    function automatic logic [23:0] mdl_vec();
        logic [11:0] oh;
        oh = 12'(bit_of(m_id[0]) | bit_of(m_id[1]));
        return {m_busy[0] != 0, 4'(m_id[0]), m_busy[1] != 0, 4'(m_id[1]),
                oh, m_to[0] != 0, m_to[1] != 0};
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_busy[u] = 0; m_id[u] = 0; m_age[u] = 0; m_to[u] = 0;
        end
    endtask

    task automatic model_edge(input int r, input int da, input int db);
        int held, elig, f, s, idle0, idle1;
        int dn[2];
        dn[0] = da; dn[1] = db;
        held = 0;
        for (int u = 0; u < 2; u++) if (m_busy[u] != 0) held |= bit_of(m_id[u]);
        elig  = r & ~held & 12'hFFF;
        f     = highest(elig);
        s     = highest(elig & ~bit_of(f));
        idle0 = (m_busy[0] == 0);
        idle1 = (m_busy[1] == 0);
        for (int u = 0; u < 2; u++) begin
            m_to[u] = 0;
            if (m_busy[u] != 0) begin
                if (dn[u] != 0) begin
                    m_busy[u] = 0; m_id[u] = 0;
                end else if (m_age[u] == HOLD) begin
                    m_busy[u] = 0; m_id[u] = 0; m_to[u] = 1;
                end else begin
                    m_age[u]++;
                end
            end
        end
        if (idle0 != 0 && idle1 != 0) begin
            if (f != 0) begin m_busy[0] = 1; m_id[0] = f; m_age[0] = 1; end
            if (s != 0) begin m_busy[1] = 1; m_id[1] = s; m_age[1] = 1; end
        end else if (idle0 != 0) begin
            if (f != 0) begin m_busy[0] = 1; m_id[0] = f; m_age[0] = 1; end
        end else if (idle1 != 0) begin
            if (f != 0) begin m_busy[1] = 1; m_id[1] = f; m_age[1] = 1; end
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle 1 time unit.
    task automatic step(input logic [11:0] r, input logic da, input logic db);
        req = r; done_a = da; done_b = db;
        @(posedge clk);
        model_edge(int'(r), int'(da), int'(db));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; done_a = 1'b0; done_b = 1'b0;
        model_reset();
        #2;
        reset = 1'b0;
        @(posedge clk);
        model_edge(0, 0, 0);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec !== 24'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 24'h0);
        end
        step(12'h800, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd12 || gnt_a_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: got a_valid=%b a_id=%0d want 1/12", gnt_a_valid, gnt_a_id);
        end
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (gnt_a_valid !== 1'b0 || gnt_onehot !== 12'h0) begin
            errors++;
            $display("FAIL reset_async: got a_valid=%b onehot=%h want 0/000", gnt_a_valid, gnt_onehot);
        end
        req = 12'h801;
        #2;
        reset = 1'b0;
        step(12'h801, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd12 || gnt_b_id !== 4'd1 || dut_vec !== mdl_vec()) begin
            errors++;
            $display("FAIL reset_restart: got a=%0d b=%0d vec=%h want 12/1 vec=%h", gnt_a_id, gnt_b_id, dut_vec, mdl_vec());
        end
    endtask

    task automatic test_dual_grant();
        do_reset();
        step(12'h801, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd12 || gnt_b_id !== 4'd1 || gnt_onehot !== 12'h801) begin
            errors++;
            $display("FAIL dual_grant: got a=%0d b=%0d oh=%h want 12/1/801", gnt_a_id, gnt_b_id, gnt_onehot);
        end
        do_reset();
        step(12'h010, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd5 || gnt_b_valid !== 1'b0 || gnt_b_id !== 4'd0 || gnt_onehot !== 12'h010) begin
            errors++;
            $display("FAIL single_grant: got a=%0d bv=%b b=%0d oh=%h want 5/0/0/010", gnt_a_id, gnt_b_valid, gnt_b_id, gnt_onehot);
        end
    endtask

    task automatic test_masking();
        do_reset();
        step(12'h800, 1'b0, 1'b0);
        step(12'hC40, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd12 || gnt_b_id !== 4'd11) begin
            errors++;
            $display("FAIL mask_grant: got a=%0d b=%0d want 12/11", gnt_a_id, gnt_b_id);
        end
        step(12'hC40, 1'b0, 1'b1);
        checks++;
        if (gnt_b_valid !== 1'b0 || gnt_b_id !== 4'd0 || gnt_onehot !== 12'h800) begin
            errors++;
            $display("FAIL mask_release: got bv=%b b=%0d oh=%h want 0/0/800", gnt_b_valid, gnt_b_id, gnt_onehot);
        end
        step(12'hC40, 1'b0, 1'b0);
        checks++;
        if (gnt_b_id !== 4'd11 || gnt_a_id !== 4'd12 || dut_vec !== mdl_vec()) begin
            errors++;
            $display("FAIL mask_regrant: got a=%0d b=%0d vec=%h want 12/11 vec=%h", gnt_a_id, gnt_b_id, dut_vec, mdl_vec());
        end
    endtask

    task automatic test_simultaneous_release();
        do_reset();
        step(12'h801, 1'b0, 1'b0);
        step(12'h0A0, 1'b1, 1'b1);
        checks++;
        if (gnt_a_valid !== 1'b0 || gnt_b_valid !== 1'b0 || gnt_onehot !== 12'h0) begin
            errors++;
            $display("FAIL simul_idle: got av=%b bv=%b oh=%h want 0/0/000", gnt_a_valid, gnt_b_valid, gnt_onehot);
        end
        step(12'h0A0, 1'b0, 1'b0);
        checks++;
        if (gnt_a_id !== 4'd8 || gnt_b_id !== 4'd6 || gnt_onehot !== 12'h0A0) begin
            errors++;
            $display("FAIL simul_regrant: got a=%0d b=%0d oh=%h want 8/6/0a0", gnt_a_id, gnt_b_id, gnt_onehot);
        end
    endtask

    // with_done: done_a arrives in the last allowed BUSY cycle.
    task automatic test_timeout(input logic with_done);
        int valid_cycles, pulses;
        do_reset();
        step(12'h800, 1'b0, 1'b0);
        valid_cycles = gnt_a_valid ? 1 : 0;
        pulses = 0;
        for (int k = 1; k <= HOLD + 4; k++) begin
            step(12'h000, (with_done && k == HOLD) ? 1'b1 : 1'b0, 1'b0);
            if (gnt_a_valid === 1'b1) valid_cycles++;
            if (timeout_a === 1'b1) pulses++;
        end
        checks++;
        if (valid_cycles != HOLD) begin
            errors++;
            $display("FAIL timeout_len(done=%b): got %0d cycles want %0d", with_done, valid_cycles, HOLD);
        end
        checks++;
        if (pulses != (with_done ? 0 : 1)) begin
            errors++;
            $display("FAIL timeout_pulse(done=%b): got %0d pulses want %0d", with_done, pulses, with_done ? 0 : 1);
        end
    endtask

    task automatic test_stray_done();
        do_reset();
        step(12'h000, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== 24'h0) begin
            errors++;
            $display("FAIL stray_done: got %h want %h", dut_vec, 24'h0);
        end
    endtask

    task automatic test_random();
        logic [11:0] r;
        logic da, db;
        int bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            r  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            da = ($urandom_range(0, 5) == 0);
            db = ($urandom_range(0, 5) == 0);
            step(r, da, db);
            checks++;
            if (dut_vec !== mdl_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got %h want %h", n, dut_vec, mdl_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_dual_grant();
        test_masking();
        test_simultaneous_release();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stray_done();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
